mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one variable-latency memory port between instruction fetch (IF) and data access (MEM stage) in the 5-stage pipeline.
- Data requests have fixed priority over fetch, because they belong to the older instruction.
- Returns read data to each requester and raises per-stage stall requests. The hazard/stall logic ORs these into its freeze and flush terms.
- A timeout watchdog ends any transaction the memory never answers, so the pipeline cannot deadlock.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles to wait for memReady per transaction; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- iReq  in  1  fetch request; held until iValid.
- iAddr  in  ADDR_W  fetch address.
- iRdata  out  DATA_W  fetched instruction (registered).
- iValid  out  1  one-cycle fetch completion pulse.
- stallF  out  1  fetch waiting; equals iReq & ~iValid.
- dReq  in  1  data request; held until dValid.
- dWe  in  1  1 = store, 0 = load.
- dBe  in  DATA_W/8  byte enables for stores.
- dAddr  in  ADDR_W  data address.
- dWdata  in  DATA_W  store data.
- dRdata  out  DATA_W  load data (registered).
- dValid  out  1  one-cycle data completion pulse.
- stallM  out  1  data access waiting; equals dReq & ~dValid.
- memReq  out  1  memory request (registered).
- memWe  out  1  memory write enable (registered).
- memBe  out  DATA_W/8  byte enables (registered).
- memAddr  out  ADDR_W  memory address (registered).
- memWdata  out  DATA_W  memory write data (registered).
- memRdata  in  DATA_W  memory read data; valid when memReady=1.
- memReady  in  1  memory completion strobe.
- busErr  out  1  one-cycle pulse, coincident with a timeout-terminated valid.
- busErrSrc  out  1  0 = fetch timed out, 1 = data timed out; holds until the next error.

Behaviour:
- Reset: clk and rst only; rst is synchronous, active-high.
  - State goes to IDLE.
  - memReq, memWe, memBe, memAddr, memWdata, iRdata, dRdata, iValid, dValid, busErr, busErrSrc and the timeout counter all clear to 0.
  - Reset asserted mid-transaction drops memReq on that same edge. The transaction is abandoned and no valid pulse is produced.
- FSM states: IDLE, IBUSY, DBUSY.
- IDLE:
  - dReq=1: latch dAddr, dWe, dBe and dWdata into the mem* registers, set memReq=1 and go to DBUSY. This wins even if iReq=1.
  - Else iReq=1: latch iAddr, with memWe=0 and memBe all-ones; set memReq=1 and go to IBUSY.
  - Request-to-memReq latency is 1 cycle.
- BUSY states:
  - mem* outputs hold stable while memReq=1.
  - The counter increments each cycle memReady=0.
- Completion: memReady=1 sampled in BUSY.
  - Loads and fetches capture memRdata into dRdata / iRdata. Stores load 0 into dRdata.
  - Pulse the owner's valid for exactly one cycle (the cycle after memReady).
  - Clear the counter.
- Back-to-back issue: the completion edge is also an arbitration edge, but only the other requester is eligible.
  - The completing requester's req is still high on that edge and must not re-issue.
  - If the other requester is eligible, load the mem* registers and keep memReq=1 with no bubble; otherwise clear memReq and go to IDLE.
  - Example: DBUSY completes with iReq=1 → IBUSY on the same edge.
- Timeout: with TIMEOUT>0, if the counter reaches TIMEOUT while memReady=0:
  - Treat this as a completion with read data 0.
  - Pulse busErr together with the owner's valid and set busErrSrc.
  - Arbitration continues exactly as on a normal completion.
  - A memReady arriving after the timeout is ignored.
- Counter width: clog2(TIMEOUT+1) bits; it saturates and never wraps.
- stallF and stallM are combinational from registered valids, with no dependence on memory inputs.
- A requester dropping req before its valid is illegal. Behaviour is undefined; the checker asserts that this never happens.
- Only one valid (iValid or dValid) pulses in any cycle.

Test Plan:
- Single fetch: iReq=1, iAddr=0x0000_0040; memReady high 2 cycles after memReq, memRdata=0x2402_0005 → memReq 1 cycle after iReq, iRdata=0x24020005 with iValid pulsed once, stallF high until that pulse.
- Simultaneous requests: iReq=dReq=1 in IDLE, dWe=0, dAddr=0x100 → data served first (memAddr=0x100); at its completion memAddr switches to iAddr with memReq staying 1 (no bubble); dValid precedes iValid by ≥1 cycle.
- Store: dWe=1, dBe=4'b0011, dWdata=0xDEAD_BEEF → memWe=1, memBe=0011, memWdata held stable until memReady; dRdata=0, dValid pulses once.
- Timeout: TIMEOUT=4, dReq=1, memReady held 0 → dValid and busErr pulse together, busErrSrc=1, dRdata=0, memReq drops; a late memReady is ignored.
- Reset mid-op: assert rst while in IBUSY with memReq=1 → next edge memReq=0, state IDLE, no iValid; a fresh iReq after reset completes normally.
- Back-to-back fetches: iReq held across 3 fetch completions (with iAddr updated after each iValid) → each fetch gets exactly one iValid, and data still preempts when dReq rises mid-stream.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data access.
// Data has fixed priority; a watchdog terminates transactions the memory never answers.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iReq,
    input  logic [ADDR_W-1:0]   iAddr,
    output logic [DATA_W-1:0]   iRdata,
    output logic                iValid,
    output logic                stallF,
    input  logic                dReq,
    input  logic                dWe,
    input  logic [DATA_W/8-1:0] dBe,
    input  logic [ADDR_W-1:0]   dAddr,
    input  logic [DATA_W-1:0]   dWdata,
    output logic [DATA_W-1:0]   dRdata,
    output logic                dValid,
    output logic                stallM,
    output logic                memReq,
    output logic                memWe,
    output logic [DATA_W/8-1:0] memBe,
    output logic [ADDR_W-1:0]   memAddr,
    output logic [DATA_W-1:0]   memWdata,
    input  logic [DATA_W-1:0]   memRdata,
    input  logic                memReady,
    output logic                busErr,
    output logic                busErrSrc
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                memReq_q, memWe_q;
    logic [BE_W-1:0]     memBe_q;
    logic [ADDR_W-1:0]   memAddr_q;
    logic [DATA_W-1:0]   memWdata_q, iRdata_q, dRdata_q;
    logic                iValid_q, dValid_q, busErr_q, busErrSrc_q;
    logic                holdF_q, holdM_q;

    logic                iElig, dElig, timedOut, done, issueD, issueI;
    logic [DATA_W-1:0]   capData;

    // A requester whose valid is showing this cycle still holds req; it is not a new request.
    assign iElig    = iReq & ~iValid_q;
    assign dElig    = dReq & ~dValid_q;
    assign timedOut = (TIMEOUT > 0) && !memReady && (cnt_q == TO_LAST);
    assign done     = (state_q != IDLE) && (memReady || timedOut);
    assign capData  = memReady ? memRdata : '0;

    // Only the requester that is not completing may take the port on a completion edge.
    assign issueD = (state_q == IDLE) ? dElig : ((state_q == IBUSY) && done && dElig);
    assign issueI = (state_q == IDLE) ? (!dElig && iElig) : ((state_q == DBUSY) && done && iElig);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            memBe_q     <= '0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            iRdata_q    <= '0;
            dRdata_q    <= '0;
            iValid_q    <= 1'b0;
            dValid_q    <= 1'b0;
            busErr_q    <= 1'b0;
            busErrSrc_q <= 1'b0;
        end else begin
            iValid_q <= 1'b0;
            dValid_q <= 1'b0;
            busErr_q <= 1'b0;
            if (done) begin
                cnt_q    <= '0;
                busErr_q <= timedOut;
                if (timedOut) begin
                    busErrSrc_q <= (state_q == DBUSY);
                end
                if (state_q == DBUSY) begin
                    dValid_q <= 1'b1;
                    dRdata_q <= memWe_q ? '0 : capData;
                end else begin
                    iValid_q <= 1'b1;
                    iRdata_q <= capData;
                end
            end else if (state_q != IDLE && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (issueD) begin
                state_q    <= DBUSY;
                memReq_q   <= 1'b1;
                memWe_q    <= dWe;
                memBe_q    <= dBe;
                memAddr_q  <= dAddr;
                memWdata_q <= dWdata;
            end else if (issueI) begin
                state_q   <= IBUSY;
                memReq_q  <= 1'b1;
                memWe_q   <= 1'b0;
                memBe_q   <= '1;
                memAddr_q <= iAddr;
            end else if (done) begin
                state_q  <= IDLE;
                memReq_q <= 1'b0;
            end
        end
    end

    // Requesters must hold req from the first stalled cycle until their valid appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdF_q <= 1'b0;
            holdM_q <= 1'b0;
        end else begin
            holdF_q <= stallF;
            holdM_q <= stallM;
            assert (!holdF_q || iReq || iValid_q);
            assert (!holdM_q || dReq || dValid_q);
        end
    end

    assign iRdata    = iRdata_q;
    assign iValid    = iValid_q;
    assign stallF    = iReq & ~iValid_q;
    assign dRdata    = dRdata_q;
    assign dValid    = dValid_q;
    assign stallM    = dReq & ~dValid_q;
    assign memReq    = memReq_q;
    assign memWe     = memWe_q;
    assign memBe     = memBe_q;
    assign memAddr   = memAddr_q;
    assign memWdata  = memWdata_q;
    assign busErr    = busErr_q;
    assign busErrSrc = busErrSrc_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized requesters and memory,
// all compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, iReq, dReq, dWe, memReady;
    logic [31:0] iAddr, dAddr, dWdata, memRdata;
    logic [3:0]  dBe;
    logic [31:0] iRdata, dRdata, memAddr, memWdata;
    logic [3:0]  memBe;
    logic        iValid, stallF, dValid, stallM, memReq, memWe, busErr, busErrSrc;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the port, how long it has waited, and the expected outputs.
    int          owner;   // 0 = nobody, 1 = fetch, 2 = data
    int          waited;
    logic        m_iv, m_dv, m_be, m_src, m_req, m_we;
    logic [3:0]  m_bel;
    logic [31:0] m_addr, m_wd, m_ird, m_drd;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iRdata(iRdata), .iValid(iValid), .stallF(stallF),
        .dReq(dReq), .dWe(dWe), .dBe(dBe), .dAddr(dAddr), .dWdata(dWdata),
        .dRdata(dRdata), .dValid(dValid), .stallM(stallM),
        .memReq(memReq), .memWe(memWe), .memBe(memBe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memReady(memReady), .busErr(busErr), .busErrSrc(busErrSrc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic start_data();
        owner = 2; m_req = 1'b1; m_we = dWe; m_bel = dBe; m_addr = dAddr; m_wd = dWdata;
    endtask

    task automatic start_fetch();
        owner = 1; m_req = 1'b1; m_we = 1'b0; m_bel = 4'hF; m_addr = iAddr;
    endtask

    task automatic model_step();
        bit ielig, delig, tout, fin;
        logic [31:0] data;
        ielig = iReq && !m_iv;
        delig = dReq && !m_dv;
        m_iv = 1'b0; m_dv = 1'b0; m_be = 1'b0;
        if (rst) begin
            owner = 0; waited = 0; m_req = 1'b0; m_we = 1'b0; m_bel = '0;
            m_addr = '0; m_wd = '0; m_ird = '0; m_drd = '0; m_src = 1'b0;
            return;
        end
        if (owner == 0) begin
            if (delig) start_data();
            else if (ielig) start_fetch();
            return;
        end
        tout = !memReady && (waited + 1 >= TO);
        fin  = memReady || tout;
        if (!fin) begin
            waited++;
            return;
        end
        data   = memReady ? memRdata : 32'h0;
        waited = 0;
        if (tout) begin
            m_be  = 1'b1;
            m_src = (owner == 2);
        end
        if (owner == 2) begin
            m_dv  = 1'b1;
            m_drd = m_we ? 32'h0 : data;
            if (ielig) start_fetch();
            else begin owner = 0; m_req = 1'b0; end
        end else begin
            m_iv  = 1'b1;
            m_ird = data;
            if (delig) start_data();
            else begin owner = 0; m_req = 1'b0; end
        end
    endtask

    task automatic compare();
        check_eq("iValid", 32'(iValid), 32'(m_iv));
        check_eq("dValid", 32'(dValid), 32'(m_dv));
        check_eq("busErr", 32'(busErr), 32'(m_be));
        check_eq("busErrSrc", 32'(busErrSrc), 32'(m_src));
        check_eq("memReq", 32'(memReq), 32'(m_req));
        check_eq("iRdata", iRdata, m_ird);
        check_eq("dRdata", dRdata, m_drd);
        check_eq("stallF", 32'(stallF), 32'(iReq && !m_iv));
        check_eq("stallM", 32'(stallM), 32'(dReq && !m_dv));
        if (m_req) begin
            check_eq("memAddr", memAddr, m_addr);
            check_eq("memWe", 32'(memWe), 32'(m_we));
            check_eq("memBe", 32'(memBe), 32'(m_bel));
            if (m_we) check_eq("memWdata", memWdata, m_wd);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    initial begin
        int fetches, dones;
        rst = 1'b1; iReq = 0; dReq = 0; dWe = 0; memReady = 0;
        iAddr = '0; dAddr = '0; dWdata = '0; memRdata = '0; dBe = '0;
        m_iv = 0; m_dv = 0;
        step(); step();
        check_eq("reset memReq", 32'(memReq), 32'd0);
        rst = 1'b0;
        step();

        // Single fetch, memory answers two cycles after memReq.
        iReq = 1; iAddr = 32'h40;
        step();
        check_eq("T1 memReq latency", 32'(memReq), 32'd1);
        step(); step();
        memReady = 1; memRdata = 32'h2402_0005;
        step();
        check_eq("T1 iRdata", iRdata, 32'h2402_0005);
        check_eq("T1 iValid", 32'(iValid), 32'd1);
        iReq = 0; memReady = 0;
        step();

        // Store: result data must read back as zero.
        dReq = 1; dWe = 1; dBe = 4'b0011; dAddr = 32'h80; dWdata = 32'hDEAD_BEEF;
        step(); step(); step();
        check_eq("T3 memWdata", memWdata, 32'hDEAD_BEEF);
        memReady = 1; memRdata = 32'hFFFF_FFFF;
        step();
        check_eq("T3 dRdata", dRdata, 32'h0);
        dReq = 0; dWe = 0; memReady = 0;
        step();

        // Simultaneous requests: data first, fetch follows with no bubble.
        iReq = 1; iAddr = 32'h200; dReq = 1; dAddr = 32'h100; dBe = 4'hF;
        step();
        check_eq("T2 data first", memAddr, 32'h100);
        memReady = 1; memRdata = 32'h1111_1111;
        step();
        check_eq("T2 dValid", 32'(dValid), 32'd1);
        check_eq("T2 no bubble", 32'(memReq), 32'd1);
        check_eq("T2 fetch addr", memAddr, 32'h200);
        dReq = 0; memReady = 0;
        step();
        memReady = 1; memRdata = 32'h2222_2222;
        step();
        check_eq("T2 iRdata", iRdata, 32'h2222_2222);
        iReq = 0; memReady = 0;
        step();

        // Watchdog on a load; a late memReady afterwards is ignored.
        dReq = 1; dAddr = 32'h300;
        step();
        repeat (TO) step();
        check_eq("T4 busErr", 32'(busErr), 32'd1);
        check_eq("T4 busErrSrc", 32'(busErrSrc), 32'd1);
        check_eq("T4 dRdata", dRdata, 32'h0);
        check_eq("T4 memReq drop", 32'(memReq), 32'd0);
        dReq = 0; memReady = 1; memRdata = 32'h55;
        step(); step();
        memReady = 0;

        // Reset in the middle of a fetch, then a clean fetch.
        iReq = 1; iAddr = 32'h44;
        step(); step();
        rst = 1; iReq = 0;
        step();
        check_eq("T5 memReq after rst", 32'(memReq), 32'd0);
        rst = 0;
        step();
        iReq = 1; iAddr = 32'h48;
        step();
        memReady = 1; memRdata = 32'h33;
        step();
        check_eq("T5 fresh fetch", iRdata, 32'h33);
        iReq = 0; memReady = 0;
        step();

        // Three back-to-back fetches with a data access arriving mid-stream.
        iReq = 1; iAddr = 32'h1000; memReady = 1; fetches = 0; dones = 0;
        for (int c = 0; c < 40 && fetches < 3; c++) begin
            memRdata = $urandom;
            step();
            if (dValid) begin dReq = 0; dones++; end
            if (iValid) begin
                fetches++;
                iAddr = iAddr + 32'd4;
                if (fetches == 3) iReq = 0;
                if (fetches == 1) begin dReq = 1; dWe = 0; dAddr = 32'h2000; end
            end
        end
        check_eq("T6 fetch count", 32'(fetches), 32'd3);
        check_eq("T6 data served", 32'(dones), 32'd1);
        memReady = 0; dReq = 0;
        step();

        // Randomized requesters, memory latency and occasional reset.
        for (int c = 0; c < 4000; c++) begin
            step();
            rst = 1'b0;
            if (iValid) iReq = 0;
            if (dValid) dReq = 0;
            if (!iReq && $urandom_range(0, 2) == 0) begin
                iReq = 1; iAddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dReq && $urandom_range(0, 2) == 0) begin
                dReq = 1; dWe = 1'($urandom); dBe = 4'($urandom);
                dAddr = $urandom; dWdata = $urandom;
            end
            memReady = ($urandom_range(0, 2) == 0);
            memRdata = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1; iReq = 0; dReq = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
